// File: rtl/rnc_packet_pkg.sv
// rnc_packet_pkg: routed spike packet layout and frame state shared by the input buffer.
package rnc_packet_pkg;
    localparam int PACKET_WIDTH = 30;
    localparam int DX_MSB = 29;
    localparam int DX_LSB = 21;
    localparam int DY_MSB = 20;
    localparam int DY_LSB = 12;
    localparam int AXON_MSB = 11;
    localparam int AXON_LSB = 4;
    localparam int TICK_MSB = 3;
    localparam int TICK_LSB = 0;
    typedef struct packed {
        logic [DX_MSB-DX_LSB:0]     dx;
        logic [DY_MSB-DY_LSB:0]     dy;
        logic [AXON_MSB-AXON_LSB:0] axon;
        logic [TICK_MSB-TICK_LSB:0] deliver_tick;
    } packet_t;
    typedef enum logic {IDLE, FILLING} frame_state_e;
endpackage

// File: rtl/rnc_input_packet_buffer_if.sv
// rnc_input_packet_buffer_if: host write / grid read bundle of the input packet buffer.
// RNC_INPUT_BUFFER_DROP_COUNT_EN adds the dropped_count signal.
interface rnc_input_packet_buffer_if #(parameter int DEPTH = 512) ();
    import rnc_packet_pkg::*;
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
    logic                 wr_en;
    packet_t              wr_packet;
    logic                 commit;
    logic                 full;
    logic                 ren;
    logic                 empty;
    packet_t              packet_out;
    logic [CNT_WIDTH-1:0] pending_count;
    logic [CNT_WIDTH-1:0] uncommitted_count;
    logic                 overflow_error;
    logic                 underflow_error;
`ifdef RNC_INPUT_BUFFER_DROP_COUNT_EN
    logic [15:0]          dropped_count;
`endif
    modport master (
        output wr_en, wr_packet, commit, ren,
        input  full, empty, packet_out, pending_count, uncommitted_count,
               overflow_error, underflow_error
`ifdef RNC_INPUT_BUFFER_DROP_COUNT_EN
        , input dropped_count
`endif
    );
    modport slave (
        input  wr_en, wr_packet, commit, ren,
        output full, empty, packet_out, pending_count, uncommitted_count,
               overflow_error, underflow_error
`ifdef RNC_INPUT_BUFFER_DROP_COUNT_EN
        , output dropped_count
`endif
    );
endinterface

// File: rtl/rnc_packet_ram.sv
// rnc_packet_ram: packet storage with one synchronous write port and one asynchronous read port.
module rnc_packet_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 30
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rnc_input_packet_buffer.sv
// rnc_input_packet_buffer: host-to-grid FWFT packet buffer that releases packets only per committed frame.
// RNC_INPUT_BUFFER_DROP_COUNT_EN adds a saturating dropped-write counter.
module rnc_input_packet_buffer
    import rnc_packet_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input logic                      clk,
    input logic                      reset_n,
    rnc_input_packet_buffer_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
    localparam int AW = CNT_WIDTH - 1;
    logic [CNT_WIDTH-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic ovf_q, ovf_d, unf_q, unf_d, wr_acc, rd_acc;
    frame_state_e state_q, state_d;
    logic [PACKET_WIDTH-1:0] rdata;
    // Extra MSB on each pointer distinguishes full from empty across wrap.
    assign bus.full = (wr_ptr_q - rd_ptr_q) == CNT_WIDTH'(DEPTH);
    assign bus.empty = rd_ptr_q == commit_ptr_q;
    assign bus.pending_count = commit_ptr_q - rd_ptr_q;
    assign bus.uncommitted_count = wr_ptr_q - commit_ptr_q;
    assign bus.overflow_error = ovf_q;
    assign bus.underflow_error = unf_q;
    assign bus.packet_out = bus.empty ? '0 : packet_t'(rdata);
    always_comb begin
        wr_acc = bus.wr_en && !bus.full;
        rd_acc = bus.ren && !bus.empty;
        wr_ptr_d = wr_ptr_q + CNT_WIDTH'(wr_acc);
        rd_ptr_d = rd_ptr_q + CNT_WIDTH'(rd_acc);
        commit_ptr_d = bus.commit ? wr_ptr_d : commit_ptr_q;
        ovf_d = ovf_q || (bus.wr_en && bus.full);
        unf_d = unf_q || (bus.ren && bus.empty);
        state_d = bus.commit ? IDLE : (wr_acc ? FILLING : state_q);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            state_q <= state_d;
        end
    end
`ifdef RNC_INPUT_BUFFER_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;
    assign bus.dropped_count = drop_q;
    always_comb begin
        drop_d = (bus.wr_en && bus.full && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else drop_q <= drop_d;
    end
`endif
    rnc_packet_ram #(.DEPTH(DEPTH), .WIDTH(PACKET_WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (bus.wr_packet),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rdata)
    );
    // Frame state tracks whether uncommitted packets exist; commit while IDLE must change nothing.
    a_state_matches: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == IDLE) == (wr_ptr_q == commit_ptr_q));
    a_idle_commit_noop: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.commit && state_q == IDLE && !wr_acc) |=> commit_ptr_q == $past(commit_ptr_q));
endmodule

// File: doc/rnc_input_packet_buffer.md
Name: rnc_input_packet_buffer

Overview:
- Host-side injection buffer that feeds the west input of core 0 in the RANC grid.
- Stores 30-bit routed spike packets written by the host and releases them to the grid through the grid's read-enable / empty handshake, in first-word-fall-through form.
- Packets are released only once the host commits a frame. A partially written frame is never visible to the grid.

Parameters:
- DEPTH, 512, packet storage entries; must be a power of two, at least 4.
- PACKET_WIDTH, 30, routed packet width: dx[29:21], dy[20:12], axon[11:4], deliver_tick[3:0].
- CNT_WIDTH, derived as log2(DEPTH)+1; pointer and occupancy width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  host write strobe.
- wr_packet  input  PACKET_WIDTH  packet to enqueue.
- commit  input  1  single-cycle pulse that makes all packets written so far deliverable.
- full  output  1  storage full; a write is dropped when this is high.
- ren  input  1  grid read enable; connects to the grid's read-enable-to-input-buffer output.
- empty  output  1  no committed packet available; connects to the grid's input-buffer-empty input.
- packet_out  output  PACKET_WIDTH  head packet, valid whenever empty is 0; connects to the grid's packet input.
- pending_count  output  CNT_WIDTH  committed packets not yet read.
- uncommitted_count  output  CNT_WIDTH  packets written but not yet committed.
- overflow_error  output  1  sticky; set by a write while full.
- underflow_error  output  1  sticky; set by ren while empty.

Behaviour:
- Reset
  - Asynchronous on reset_n low.
  - Clears rd_ptr, commit_ptr and wr_ptr, each CNT_WIDTH bits with a wrap bit.
  - Output values in reset: empty=1, full=0, both counts 0, both error flags 0, packet_out=0.
  - Storage contents are not reset. packet_out is forced to 0 whenever empty is 1.
  - Reset asserted mid-frame discards all packets, committed and uncommitted.
- Pointer relations
  - full = (wr_ptr - rd_ptr == DEPTH).
  - empty = (rd_ptr == commit_ptr).
  - pending_count = commit_ptr - rd_ptr.
  - uncommitted_count = wr_ptr - commit_ptr.
  - All subtraction is modulo 2^CNT_WIDTH.
- Write
  - wr_en with full=0: store at mem[wr_ptr[CNT_WIDTH-2:0]], then wr_ptr+1.
  - wr_en with full=1: packet dropped and overflow_error set. This holds even if ren frees an entry in the same cycle, because full is evaluated before the edge.
- Commit
  - On the edge, commit_ptr takes the value of wr_ptr after the edge. A write in the same cycle as commit is therefore included.
  - Commit with nothing uncommitted has no effect.
- Read
  - packet_out = mem[rd_ptr[CNT_WIDTH-2:0]], combinational from the storage array.
  - ren with empty=0: rd_ptr+1 on the edge, so the next packet appears in the following cycle (zero-latency FWFT).
  - ren with empty=1: ignored and underflow_error set.
- Latency
  - A committed packet is visible on packet_out with empty=0 in the cycle after the commit edge.
- Simultaneous events
  - Write, commit and read in the same cycle are all honoured independently.
  - Pointers wrap naturally through the extra MSB.
- Error flags
  - Sticky until reset.
- State machine (frame state, 2 states)
  - IDLE: uncommitted_count is 0.
  - FILLING: at least one uncommitted packet.
  - IDLE to FILLING on an accepted write without commit.
  - FILLING to IDLE on commit.
  - State is observable only through uncommitted_count. It is used internally for assertions: commit in IDLE is a no-op.

Optional Feature:
- Macro: RNC_INPUT_BUFFER_DROP_COUNT_EN.
- Defined: adds output dropped_count, 16 bits, reset to 0. It increments on each dropped write and saturates at 16'hFFFF.
- Undefined: the port and counter are absent; overflow_error is the only drop indication.

Decomposition:
- Shared package rnc_packet_pkg holds:
  - PACKET_WIDTH=30.
  - Field MSB/LSB constants: DX 29:21, DY 20:12, AXON 11:4, TICK 3:0.
  - Packet struct typedef.
- One natural sub-module, rnc_packet_ram: simple dual-port array with one synchronous write and one asynchronous read port. The pointer, commit and flag logic stays in the top module.

Test Plan:
- Reset, then write 3 packets (0x0000_0001, 0x0000_0002, 0x0000_0003) without commit: empty stays 1, uncommitted_count=3, and ren pulses set underflow_error=1.
- Commit the 3 packets, then hold ren continuously: packet_out is 1, 2, 3 on consecutive cycles, then empty=1 and pending_count=0.
- Write DEPTH packets and commit, then write once more: full=1, overflow_error=1, pending_count stays DEPTH. With the macro defined, dropped_count=1.
- Write, commit and ren in the same cycle with 1 packet pending: pending_count is unchanged (+1 -1), and the new packet is read after the old one.
- Run 3×DEPTH packets through in frames of 7 with random ren: output order matches write order across pointer wrap, with no errors.
- Assert reset_n low mid-frame with 5 pending and 2 uncommitted: immediately empty=1 and both counts 0; after release, the next commit delivers only post-reset writes.
